// File: rtl/bram_pkg.sv
// Shared types and helpers for the true-dual-port RAM with clear engine.
package bram_pkg;

    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;

    // Widest word be_merge handles; callers cast to and from their own width
    localparam int unsigned MERGE_W    = 256;
    localparam int unsigned MERGE_BE_W = MERGE_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Replace every byte of old_w whose enable is set with the same byte of new_w
    function automatic logic [MERGE_W-1:0] be_merge(
        input logic [MERGE_W-1:0]    old_w,
        input logic [MERGE_W-1:0]    new_w,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(MERGE_BE_W); i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_w[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_tdp_clr_if.sv
// Control and data bundle for both RAM ports plus the clear handshake.
interface bram_tdp_clr_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              clr_req;
    logic              busy;

    logic              en_a;
    logic              we_a;
    logic [BE_W-1:0]   be_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] din_a;
    logic [DATA_W-1:0] dout_a;
    logic              vld_a;

    logic              en_b;
    logic              we_b;
    logic [BE_W-1:0]   be_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] din_b;
    logic [DATA_W-1:0] dout_b;
    logic              vld_b;

    modport master (
        output clr_req,
        output en_a, we_a, be_a, addr_a, din_a,
        output en_b, we_b, be_b, addr_b, din_b,
        input  busy,
        input  dout_a, vld_a,
        input  dout_b, vld_b
    );

    modport slave (
        input  clr_req,
        input  en_a, we_a, be_a, addr_a, din_a,
        input  en_b, we_b, be_b, addr_b, din_b,
        output busy,
        output dout_a, vld_a,
        output dout_b, vld_b
    );

endinterface

// File: rtl/bram_clr_seq.sv
// Clear sequencer: walks every address once, emitting a zero-write per cycle.
module bram_clr_seq
    import bram_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam clr_state_t        RST_STATE = (CLR_ON_RST != 0) ? CLEAR : IDLE;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: clr_req only honoured from IDLE; leave CLEAR after the last address
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded straight from the state and counter registers
    always_comb begin
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        if (state_q == CLEAR) begin
            busy   = 1'b1;
            clr_we = 1'b1;
        end
    end

endmodule

// File: rtl/bram_tdp_clr.sv
// True-dual-port byte-writable RAM with a sequenced clear engine.
// Optional output pipeline stage: define BRAM_TDP_OUT_REG_EN (read latency 2).
module bram_tdp_clr
    import bram_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned CLR_ON_RST = 1
) (
    input logic            clk,
    input logic            rst,
    bram_tdp_clr_if.slave  bus
);

    localparam int unsigned     BE_W    = DATA_W / 8;
    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam bit              WR_FIRST = (RDW_MODE != RDW_READ_FIRST) && (RDW_MODE == RDW_WRITE_FIRST);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy, clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              acc_a, acc_b, in_a, in_b, wb_en, wa_en;
    logic [IDX_W-1:0]  idx_a, idx_b, wa_idx;
    logic [BE_W-1:0]   wa_be;
    logic [DATA_W-1:0] wa_data, old_a, old_b, rd_a, rd_b;
    logic [DATA_W-1:0] dout_a_q, dout_b_q;
    logic              vld_a_q, vld_b_q;

    bram_clr_seq #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Access qualification, port A write-path mux (clear engine wins while busy), read data
    always_comb begin
        acc_a   = bus.en_a && !busy && !rst;
        acc_b   = bus.en_b && !busy && !rst;
        in_a    = ({1'b0, bus.addr_a} < DEPTH_L);
        in_b    = ({1'b0, bus.addr_b} < DEPTH_L);
        idx_a   = IDX_W'(bus.addr_a);
        idx_b   = IDX_W'(bus.addr_b);
        wb_en   = acc_b && bus.we_b && in_b;
        wa_en   = acc_a && bus.we_a && in_a;
        wa_idx  = idx_a;
        wa_be   = bus.be_a;
        wa_data = bus.din_a;
        if (busy) begin
            wa_en   = clr_we && !rst;
            wa_idx  = IDX_W'(clr_addr);
            wa_be   = '1;
            wa_data = '0;
        end

        old_a = mem[idx_a];
        old_b = mem[idx_b];
        rd_a  = old_a;
        rd_b  = old_b;
        if (WR_FIRST && bus.we_a) begin
            rd_a = DATA_W'(be_merge(MERGE_W'(old_a), MERGE_W'(bus.din_a), MERGE_BE_W'(bus.be_a)));
        end
        if (WR_FIRST && bus.we_b) begin
            rd_b = DATA_W'(be_merge(MERGE_W'(old_b), MERGE_W'(bus.din_b), MERGE_BE_W'(bus.be_b)));
        end
        if (!in_a) rd_a = '0;
        if (!in_b) rd_b = '0;
    end

    // Byte-lane writes; on a same-address collision port A owns the bytes it enables
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BE_W); i++) begin
            if (wb_en && bus.be_b[i] && !(wa_en && wa_be[i] && (wa_idx == idx_b))) begin
                mem[idx_b][i*8 +: 8] <= bus.din_b[i*8 +: 8];
            end
            if (wa_en && wa_be[i]) begin
                mem[wa_idx][i*8 +: 8] <= wa_data[i*8 +: 8];
            end
        end
    end

    // Read registers: valid strobe per access, data held when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
            vld_a_q  <= 1'b0;
            vld_b_q  <= 1'b0;
        end else begin
            vld_a_q <= acc_a;
            vld_b_q <= acc_b;
            if (acc_a) dout_a_q <= rd_a;
            if (acc_b) dout_b_q <= rd_b;
        end
    end

`ifdef BRAM_TDP_OUT_REG_EN
    logic [DATA_W-1:0] dout_a_p, dout_b_p;
    logic              vld_a_p, vld_b_p;

    // Extra output stage; flushed to zero while the clear runs
    always_ff @(posedge clk) begin
        if (rst || busy) begin
            dout_a_p <= '0;
            dout_b_p <= '0;
            vld_a_p  <= 1'b0;
            vld_b_p  <= 1'b0;
        end else begin
            dout_a_p <= dout_a_q;
            dout_b_p <= dout_b_q;
            vld_a_p  <= vld_a_q;
            vld_b_p  <= vld_b_q;
        end
    end

    assign bus.dout_a = dout_a_p;
    assign bus.dout_b = dout_b_p;
    assign bus.vld_a  = vld_a_p;
    assign bus.vld_b  = vld_b_p;
`else
    assign bus.dout_a = dout_a_q;
    assign bus.dout_b = dout_b_q;
    assign bus.vld_a  = vld_a_q;
    assign bus.vld_b  = vld_b_q;
`endif

    assign bus.busy = busy;

endmodule

// File: tb/tb_bram_tdp_clr.sv
// Scoreboard bench: a read-first and a write-first instance share one stimulus stream.
module tb_bram_tdp_clr;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 200;
`ifdef BRAM_TDP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic        en;
        logic        we;
        logic [1:0]  be;
        logic [7:0]  addr;
        logic [15:0] din;
    } acc_t;

    typedef struct packed {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_tdp_clr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_rf ();
    bram_tdp_clr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_wf ();

    bram_tdp_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RDW_MODE(0), .CLR_ON_RST(1))
        dut_rf (.clk(clk), .rst(rst), .bus(bus_rf));
    bram_tdp_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RDW_MODE(1), .CLR_ON_RST(1))
        dut_wf (.clk(clk), .rst(rst), .bus(bus_wf));

    assign bus_wf.clr_req = bus_rf.clr_req;
    assign bus_wf.en_a    = bus_rf.en_a;
    assign bus_wf.we_a    = bus_rf.we_a;
    assign bus_wf.be_a    = bus_rf.be_a;
    assign bus_wf.addr_a  = bus_rf.addr_a;
    assign bus_wf.din_a   = bus_rf.din_a;
    assign bus_wf.en_b    = bus_rf.en_b;
    assign bus_wf.we_b    = bus_rf.we_b;
    assign bus_wf.be_b    = bus_rf.be_b;
    assign bus_wf.addr_b  = bus_rf.addr_b;
    assign bus_wf.din_b   = bus_rf.din_b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int run [2];

    // Reference model: plain word array, cleared wholesale when a clear starts
    logic [15:0] mdl [DEPTH];
    bit          mb = 1'b1;
    exp_t        q0[$], q1[$], q2[$], q3[$];

    function automatic logic [15:0] mrg(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        logic [15:0] r;
        r = o;
        if (be[0]) r[7:0]  = n[7:0];
        if (be[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    function automatic string nm(input int s);
        case (s)
            0: return "rf_port_a";
            1: return "rf_port_b";
            2: return "wf_port_a";
            default: return "wf_port_b";
        endcase
    endfunction

    function automatic acc_t nop();
        return acc_t'(0);
    endfunction

    function automatic acc_t rd(input logic [7:0] addr);
        acc_t x;
        x = '0;
        x.en = 1'b1;
        x.addr = addr;
        return x;
    endfunction

    function automatic acc_t wr(input logic [7:0] addr, input logic [15:0] din, input logic [1:0] be);
        acc_t x;
        x.en = 1'b1;
        x.we = 1'b1;
        x.be = be;
        x.addr = addr;
        x.din = din;
        return x;
    endfunction

    function automatic acc_t rnd_acc();
        acc_t x;
        x.en   = ($urandom_range(0, 3) != 0);
        x.we   = 1'($urandom_range(0, 1));
        x.be   = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
            0:       x.addr = 8'($urandom_range(0, 255));
            1:       x.addr = 8'($urandom_range(198, 201));
            default: x.addr = 8'($urandom_range(0, 7));
        endcase
        x.din  = 16'($urandom);
        return x;
    endfunction

    task automatic start_clear();
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 16'h0000;
        mb = 1'b1;
    endtask

    // Expected responses follow from the model state before this cycle's writes
    task automatic model_step(input acc_t a, input acc_t b);
        logic [15:0] old_a, old_b;
        bit ina, inb;
        ina = (int'(a.addr) < int'(DEPTH));
        inb = (int'(b.addr) < int'(DEPTH));
        old_a = ina ? mdl[a.addr] : 16'h0000;
        old_b = inb ? mdl[b.addr] : 16'h0000;
        if (a.en) begin
            q0.push_back('{old_a, cyc + LAT});
            q2.push_back('{(a.we && ina) ? mrg(old_a, a.din, a.be) : old_a, cyc + LAT});
        end
        if (b.en) begin
            q1.push_back('{old_b, cyc + LAT});
            q3.push_back('{(b.we && inb) ? mrg(old_b, b.din, b.be) : old_b, cyc + LAT});
        end
        if (b.en && b.we && inb) mdl[b.addr] = mrg(mdl[b.addr], b.din, b.be);
        if (a.en && a.we && ina) mdl[a.addr] = mrg(mdl[a.addr], a.din, a.be);
    endtask

    task automatic issue(input acc_t a, input acc_t b, input logic creq, input logic r);
        bus_rf.en_a    = a.en;
        bus_rf.we_a    = a.we;
        bus_rf.be_a    = a.be;
        bus_rf.addr_a  = a.addr;
        bus_rf.din_a   = a.din;
        bus_rf.en_b    = b.en;
        bus_rf.we_b    = b.we;
        bus_rf.be_b    = b.be;
        bus_rf.addr_b  = b.addr;
        bus_rf.din_b   = b.din;
        bus_rf.clr_req = creq;
        rst            = r;
        if (!mb && !r) model_step(a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(nop(), nop(), 1'b0, 1'b0);
    endtask

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic pop(input int s);
        case (s)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    // Monitor: pop the oldest expectation of a stream whenever its valid is seen
    task automatic chk(input int s, input logic v, input logic [15:0] d);
        exp_t e;
        int   n;
        e = '0;
        case (s)
            0: n = q0.size();
            1: n = q1.size();
            2: n = q2.size();
            default: n = q3.size();
        endcase
        if (n > 0) begin
            case (s)
                0: e = q0[0];
                1: e = q1[0];
                2: e = q2[0];
                default: e = q3[0];
            endcase
        end
        if (v === 1'b1) begin
            n_chk++;
            if (n == 0) begin
                $display("FAIL %s: unexpected vld at cycle %0d, dout=%h", nm(s), cyc, d);
            end else begin
                pop(s);
                if (d === e.data && cyc == e.due) n_pass++;
                else $display("FAIL %s: dout=%h at cycle %0d, required %h at cycle %0d",
                              nm(s), d, cyc, e.data, e.due);
            end
        end else if (n > 0 && cyc > e.due) begin
            n_chk++;
            pop(s);
            $display("FAIL %s: no vld by cycle %0d, required %h at cycle %0d", nm(s), cyc, e.data, e.due);
        end
    endtask

    // Busy run length must equal DEPTH each time a clear completes
    task automatic busy_track(input int k, input logic b);
        if (rst) begin
            run[k] = 0;
        end else if (b === 1'b1) begin
            run[k] = run[k] + 1;
        end else if (run[k] != 0) begin
            n_chk++;
            if (run[k] == int'(DEPTH)) n_pass++;
            else $display("FAIL busy_len_%0d: got %0d cycles, required %0d", k, run[k], DEPTH);
            run[k] = 0;
        end
    endtask

    always @(negedge clk) begin
        chk(0, bus_rf.vld_a, bus_rf.dout_a);
        chk(1, bus_rf.vld_b, bus_rf.dout_b);
        chk(2, bus_wf.vld_a, bus_wf.dout_a);
        chk(3, bus_wf.vld_b, bus_wf.dout_b);
        busy_track(0, bus_rf.busy);
        busy_track(1, bus_wf.busy);
    end

    initial begin
        run[0] = 0;
        run[1] = 0;
        start_clear();
        for (int i = 0; i < 3; i++) issue(nop(), nop(), 1'b0, 1'b1);
        expect_eq("rst_dout_a", 32'(bus_rf.dout_a), 32'h0);
        expect_eq("rst_dout_b", 32'(bus_wf.dout_b), 32'h0);
        expect_eq("rst_vld",    32'({bus_rf.vld_a, bus_rf.vld_b, bus_wf.vld_a, bus_wf.vld_b}), 32'h0);
        expect_eq("rst_busy",   32'({bus_rf.busy, bus_wf.busy}), 32'h3);
        idle(int'(DEPTH) + 2);
        mb = 1'b0;

        // Reads after the reset clear, including an out-of-range address
        issue(rd(8'h00), rd(8'h7F), 1'b0, 1'b0);
        issue(rd(8'hFF), rd(8'hC7), 1'b0, 1'b0);
        // Byte enables
        issue(wr(8'h10, 16'hABCD, 2'b11), nop(), 1'b0, 1'b0);
        issue(wr(8'h10, 16'h1234, 2'b01), nop(), 1'b0, 1'b0);
        issue(nop(), rd(8'h10), 1'b0, 1'b0);
        // Same-port read-during-write, then a plain read
        issue(wr(8'h20, 16'h1111, 2'b11), nop(), 1'b0, 1'b0);
        issue(wr(8'h20, 16'h2222, 2'b11), nop(), 1'b0, 1'b0);
        issue(rd(8'h20), nop(), 1'b0, 1'b0);
        // Dual-port write collision
        issue(wr(8'h30, 16'hAAAA, 2'b10), wr(8'h30, 16'hBBBB, 2'b11), 1'b0, 1'b0);
        issue(rd(8'h30), rd(8'h30), 1'b0, 1'b0);
        // One port writes, the other reads the same address
        issue(wr(8'h40, 16'h7777, 2'b11), rd(8'h40), 1'b0, 1'b0);
        issue(rd(8'h40), wr(8'h40, 16'h9999, 2'b01), 1'b0, 1'b0);
        issue(rd(8'h40), nop(), 1'b0, 1'b0);
        // Out-of-range write and read back, last in-range word
        issue(wr(8'hF0, 16'h1234, 2'b11), wr(8'hC7, 16'h5A5A, 2'b11), 1'b0, 1'b0);
        issue(rd(8'hF0), rd(8'hC7), 1'b0, 1'b0);
        issue(wr(8'h05, 16'hCAFE, 2'b11), nop(), 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) issue(rnd_acc(), rnd_acc(), 1'b0, 1'b0);

        // Requested clear with a dropped write and a repeated request while busy
        idle(3);
        issue(nop(), nop(), 1'b1, 1'b0);
        start_clear();
        idle(20);
        issue(wr(8'h05, 16'h5555, 2'b11), rd(8'h06), 1'b0, 1'b0);
        idle(30);
        issue(nop(), nop(), 1'b1, 1'b0);
        idle(int'(DEPTH) - 50);
        mb = 1'b0;
        issue(rd(8'h05), rd(8'h10), 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) issue(rnd_acc(), rnd_acc(), 1'b0, 1'b0);

        // Reset in the middle of a clear restarts it
        idle(3);
        issue(nop(), nop(), 1'b1, 1'b0);
        start_clear();
        idle(99);
        issue(nop(), nop(), 1'b0, 1'b1);
        idle(int'(DEPTH) + 2);
        mb = 1'b0;
        issue(rd(8'h00), rd(8'hC7), 1'b0, 1'b0);
        for (int i = 0; i < 150; i++) issue(rnd_acc(), rnd_acc(), 1'b0, 1'b0);

        idle(5);
        expect_eq("drain_q_rf_a", 32'(q0.size()), 32'h0);
        expect_eq("drain_q_rf_b", 32'(q1.size()), 32'h0);
        expect_eq("drain_q_wf_a", 32'(q2.size()), 32'h0);
        expect_eq("drain_q_wf_b", 32'(q3.size()), 32'h0);
        expect_eq("end_busy",     32'({bus_rf.busy, bus_wf.busy}), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bram_tdp_clr.md
Name: bram_tdp_clr

Overview:
- Parametrised true-dual-port block RAM; the successor to the single-port 256x16 test RAM in the dsp_bram_tests benchmarks.
- Adds the following over the single-port RAM:
  - generic width and depth
  - a second independent read/write port
  - per-byte write enables
  - selectable read-during-write mode
  - a sequenced memory-clear engine
- Targets FPGA BRAM inference in the benchmark fabric; the clear engine drives the write path so the array still maps to a hard BRAM.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 8, address width.
- DEPTH, 256, number of words; must be <= 2**ADDR_W.
- RDW_MODE, 0, same-port read-during-write result: 0 = read-first (old data), 1 = write-first (new data).
- CLR_ON_RST, 1, 1 = run the clear sequence automatically after reset; 0 = clear only on clr_req.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- clr_req  in  1  single-cycle pulse; requests zeroing of the whole array.
- busy  out  1  high while the clear sequence runs.
- en_a  in  1  port A access enable.
- we_a  in  1  port A write (valid only with en_a).
- be_a  in  DATA_W/8  port A byte enables.
- addr_a  in  ADDR_W  port A address.
- din_a  in  DATA_W  port A write data.
- dout_a  out  DATA_W  port A read data.
- vld_a  out  1  dout_a valid strobe.
- en_b, we_b, be_b, addr_b, din_b, dout_b, vld_b: same as port A, for port B.

Behaviour:
- Reset values: dout_a = dout_b = 0; vld_a = vld_b = 0; busy = CLR_ON_RST.
  - Array contents are not reset directly.
  - rst asserted during a clear aborts it; the FSM restarts per CLR_ON_RST.
- FSM states: IDLE, CLEAR.
  - rst: next state is CLEAR if CLR_ON_RST, else IDLE; the clear counter is zeroed.
  - IDLE -> CLEAR on clr_req; the counter is zeroed.
  - In CLEAR: writes 0 to address cnt through the port A write path each cycle, then cnt++.
  - CLEAR -> IDLE in the cycle after cnt == DEPTH-1 is written, so the clear takes exactly DEPTH cycles.
  - busy = (state == CLEAR).
  - clr_req while busy is ignored.
- Port access while busy:
  - Both ports' en are ignored; no writes, no reads.
  - vld_a and vld_b stay 0.
- Read latency: 1 cycle.
  - An access with en_x=1 in cycle N gives dout_x and vld_x=1 in cycle N+1.
  - This holds for writes too: dout shows the RDW_MODE result.
  - vld_x=0 in any cycle following no access; dout_x then holds its last value.
- Byte write: byte i of the word is written iff we_x & be_x[i]; unselected bytes are unchanged.
  - we_x with be_x = 0 behaves as a read.
- Same-port read-during-write:
  - RDW_MODE=0: dout returns the pre-write word.
  - RDW_MODE=1: dout returns the merged post-write word.
- Cross-port collision (same address, same cycle):
  - Both writing: port A wins on each byte it enables; port B writes only the bytes A does not enable.
  - One writing, other reading: the reader gets old data regardless of RDW_MODE.
- Addresses >= DEPTH:
  - Writes are dropped.
  - Reads return 0 with vld=1.
- No wrap-around of out-of-range addresses.

Optional Feature:
- Macro: BRAM_TDP_OUT_REG_EN.
- Defined:
  - Adds an output pipeline register on dout_x and vld_x; read latency becomes 2 cycles.
  - The register resets to 0 and is held at 0 while busy.
- Undefined: latency is 1 cycle, as above.
- The clear length (DEPTH cycles) and busy timing are the same in both builds.

Decomposition:
- Shared package bram_pkg:
  - localparams RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1
  - enum clr_state_t {IDLE, CLEAR}
  - function be_merge(old, new, be) returning the byte-merged word
- One natural sub-module: bram_clr_seq.
  - Contains the FSM and counter.
  - Outputs busy, clr_we, clr_addr.
  - The top muxes clr_* onto the port A write path.

Test Plan:
- Reset clear, CLR_ON_RST=1, DEPTH=256:
  - Stimulus: pulse rst, then read addr 0x00, 0x7F and 0xFF.
  - Required: busy high for exactly 256 cycles; all three reads return 0x0000 with vld=1.
- Byte enables:
  - Stimulus: write A addr 0x10 = 0xABCD with be=11, then write A addr 0x10 = 0x1234 with be=01, then read B addr 0x10.
  - Required: read returns 0xAB34.
- Read-during-write:
  - Stimulus: addr 0x20 holds 0x1111; write 0x2222 on port A.
  - Required: RDW_MODE=0 gives dout_a=0x1111; RDW_MODE=1 gives dout_a=0x2222; a following read returns 0x2222.
- Dual-port collision:
  - Stimulus: in the same cycle, A writes 0xAAAA with be=10 and B writes 0xBBBB with be=11, both to addr 0x30.
  - Required: a later read returns 0xAABB.
- Mid-clear events:
  - Stimulus: clr_req pulse; en_a/we_a writes 0x5555 to addr 0x05 during busy; clr_req repeated during busy.
  - Required: the write is dropped; vld_a=0 throughout busy; busy lasts exactly DEPTH cycles.
  - Stimulus: rst asserted at clear cycle 100.
  - Required: clear restarts from addr 0.
- Out of range and output register:
  - Stimulus: DEPTH=200; write addr 0xF0, then read it back.
  - Required: read returns 0 with vld=1.
  - Stimulus: rebuild with BRAM_TDP_OUT_REG_EN defined; read addr 0x10 issued at cycle N.
  - Required: vld_b=1 at cycle N+2.
